// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, FSM encoding and sign helpers.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_NOR   = 4'h4;
  localparam logic [3:0] OP_SLT   = 4'h5;
  localparam logic [3:0] OP_SLL   = 4'h6;
  localparam logic [3:0] OP_SRL   = 4'h7;
  localparam logic [3:0] OP_MULT  = 4'h8;
  localparam logic [3:0] OP_DIV   = 4'h9;
  localparam logic [3:0] OP_SRA   = 4'hA;
  localparam logic [3:0] OP_MULTU = 4'hB;
  localparam logic [3:0] OP_DIVU  = 4'hC;
  localparam logic [3:0] OP_SLTU  = 4'hD;
  localparam logic [3:0] OP_XOR   = 4'hE;

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Returns {negate_lo, negate_hi}; the remainder follows the dividend's sign.
  function automatic logic [1:0] sign_fix(input logic is_div, input logic a_neg,
                                          input logic b_neg);
    if (is_div) return {a_neg ^ b_neg, a_neg};
    return {a_neg ^ b_neg, a_neg ^ b_neg};
  endfunction

endpackage

// File: rtl/alu_muldiv_core.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
module alu_muldiv_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             fin,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0]   cnt;
  logic               div_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_diff;

  // Multiply: add into the upper half and shift right. Divide: shift left, trial-subtract.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc[0]}} & b_q};
    rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, b_q};
    acc_nxt  = {mul_sum, acc[WIDTH-1:1]};
    if (div_q) begin
      if (!rem_diff[WIDTH]) acc_nxt = {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else                  acc_nxt = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst)            cnt <= '0;
    else if (load)      cnt <= CNT_W'(WIDTH);
    else if (cnt != '0) cnt <= cnt - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (load) begin
      acc   <= {{WIDTH{1'b0}}, a};
      b_q   <= b;
      div_q <= is_div;
    end else if (busy) begin
      acc <= acc_nxt;
    end
  end

  assign busy = (cnt != '0);
  assign fin  = (cnt == CNT_W'(1));
  assign hi   = acc[2*WIDTH-1:WIDTH];
  assign lo   = acc[WIDTH-1:0];

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative signed/unsigned MULT/DIV.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             overflow,
  output logic             div_by_zero,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  state_t state, state_nxt;

  logic signed [WIDTH-1:0] sa, sb;
  logic [WIDTH-1:0]        a_abs, b_abs, sum, diff, alu_res;
  logic [SHAMT_W-1:0]      shamt;
  logic                    alu_ovf, a_neg, b_neg, signed_op, is_div_op, dz, launch, min_by_m1;
  logic                    neg_lo_q, neg_hi_q, div_q, ovf_pend_q;
  logic                    core_busy, core_fin;
  logic [WIDTH-1:0]        core_hi, core_lo;

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic neg, input logic [2*WIDTH-1:0] v);
    return neg ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic neg, input logic [WIDTH-1:0] v);
    return neg ? -v : v;
  endfunction

  assign sa    = src_a;
  assign sb    = src_b;
  assign shamt = src_a[SHAMT_W-1:0];

  always_comb begin
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    is_div_op = (op == OP_DIV) || (op == OP_DIVU);
    dz        = is_div_op && (src_b == '0);
    a_neg     = signed_op && src_a[WIDTH-1];
    b_neg     = signed_op && src_b[WIDTH-1];
    a_abs     = cond_neg(a_neg, src_a);
    b_abs     = cond_neg(b_neg, src_b);
    min_by_m1 = (op == OP_DIV) && (src_a == {1'b1, {(WIDTH-1){1'b0}}}) && (src_b == '1);
    launch    = (state == IDLE) && start && is_muldiv(op) && !dz;
  end

  always_comb begin
    sum     = src_a + src_b;
    diff    = src_a - src_b;
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (diff[WIDTH-1] != src_a[WIDTH-1]);
      end
      OP_AND:  alu_res = src_a & src_b;
      OP_OR:   alu_res = src_a | src_b;
      OP_NOR:  alu_res = ~(src_a | src_b);
      OP_XOR:  alu_res = src_a ^ src_b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, sa < sb};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, src_a < src_b};
      OP_SLL:  alu_res = src_b << shamt;
      OP_SRL:  alu_res = src_b >> shamt;
      OP_SRA:  alu_res = sb >>> shamt;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (launch) state_nxt = is_div_op ? DIV : MUL;
      MUL, DIV: if (core_fin || !core_busy) state_nxt = FIX;
      FIX:      state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Launch/complete stage: single-cycle results, operand sign capture, final sign fixup.
  always_ff @(posedge clk) begin
    if (rst) begin
      result      <= '0;
      hi          <= '0;
      lo          <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (dz) begin
            hi          <= '0;
            lo          <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b1;
            done        <= 1'b1;
          end else if (is_muldiv(op)) begin
            {neg_lo_q, neg_hi_q} <= sign_fix(is_div_op, a_neg, b_neg);
            div_q                <= is_div_op;
            ovf_pend_q           <= min_by_m1;
          end else begin
            result      <= alu_res;
            overflow    <= alu_ovf;
            div_by_zero <= 1'b0;
            done        <= 1'b1;
          end
        end
        FIX: begin
          if (div_q) begin
            lo <= cond_neg(neg_lo_q, core_lo);
            hi <= cond_neg(neg_hi_q, core_hi);
          end else begin
            {hi, lo} <= cond_neg2(neg_lo_q, {core_hi, core_lo});
          end
          overflow    <= ovf_pend_q;
          div_by_zero <= 1'b0;
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  alu_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (launch),
    .is_div (is_div_op),
    .a      (a_abs),
    .b      (b_abs),
    .busy   (core_busy),
    .fin    (core_fin),
    .hi     (core_hi),
    .lo     (core_lo)
  );

  assign busy = (state == MUL) || (state == DIV) || (state == FIX);
  assign zero = (result == '0);

endmodule
